// File: rtl/rom_dl_sched.sv
// rom_dl_sched: schedules ROM download bytes onto two SDRAM toggle-handshake ports, drives PROM writes and the core reset
module rom_dl_sched #(
  parameter logic [24:0] SP_BASE = 25'h30000,
  parameter logic [24:0] PROM_BASE = 25'hA0000,
  parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        prom_wr,
  output logic [11:0] prom_addr,
  output logic [7:0]  prom_d,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0] state;
  logic p2_open, wr_d, downl_d, buf_v, load_pend;
  logic [24:0] buf_a;
  logic [7:0] buf_d;
  logic [15:0] cnt;
  logic capture, drain, done, fall, to_sp, to_prom;
  logic [23:0] sp_off;
  logic [11:0] pr_off;
  always_comb begin
    capture = ioctl_wr && !wr_d && ioctl_downl;
    drain = (state == IDLE) && buf_v;
    done = (port1_ack == port1_req) && (!p2_open || (port2_ack == port2_req));
    fall = downl_d && !ioctl_downl;
    to_sp = buf_a >= SP_BASE;
    to_prom = (buf_a >= PROM_BASE) && (buf_a < PROM_BASE + 25'd4096);
    sp_off = buf_a[23:0] - SP_BASE[23:0];
    pr_off = buf_a[11:0] - PROM_BASE[11:0];
  end
  always_ff @(posedge clk_sys) begin
    wr_d <= ioctl_wr;
    downl_d <= ioctl_downl;
    if (reset) begin
      state <= IDLE;
      p2_open <= 1'b0;
      buf_v <= 1'b0;
      buf_a <= '0;
      buf_d <= '0;
      load_pend <= 1'b0;
      port1_req <= 1'b0;
      port1_a <= '0;
      port1_ds <= '0;
      port1_d <= '0;
      port2_req <= 1'b0;
      port2_a <= '0;
      port2_ds <= '0;
      port2_d <= '0;
      prom_wr <= 1'b0;
      prom_addr <= '0;
      prom_d <= '0;
      rom_loaded <= 1'b0;
      overflow <= 1'b0;
      cnt <= RESET_HOLD;
      core_reset <= 1'b1;
    end else begin
      if (capture && buf_v && !drain) overflow <= 1'b1;
      else if (capture) begin
        buf_v <= 1'b1;
        buf_a <= ioctl_addr;
        buf_d <= ioctl_dout;
      end else if (drain) buf_v <= 1'b0;
      prom_wr <= 1'b0;
      if (drain) begin
        state <= WAIT;
        p2_open <= to_sp;
        port1_req <= ~port1_req;
        port1_a <= buf_a[23:1];
        port1_ds <= {buf_a[0], ~buf_a[0]};
        port1_d <= {buf_d, buf_d};
        if (to_sp) begin
          port2_req <= ~port2_req;
          port2_a <= sp_off[23:1];
          port2_ds <= {sp_off[0], ~sp_off[0]};
          port2_d <= {buf_d, buf_d};
        end
        if (to_prom) begin
          prom_wr <= 1'b1;
          prom_addr <= pr_off;
          prom_d <= buf_d;
        end
      end else if (state == WAIT && done) state <= IDLE;
      if ((load_pend || fall) && state == IDLE && !buf_v) begin
        rom_loaded <= 1'b1;
        load_pend <= 1'b0;
      end else if (fall) load_pend <= 1'b1;
      cnt <= (user_reset || ioctl_downl || !rom_loaded) ? RESET_HOLD : (cnt != 16'd0) ? cnt - 16'd1 : cnt;
      core_reset <= cnt != 16'd0;
    end
  end
endmodule

// File: tb/tb_rom_dl_sched.sv
// tb_rom_dl_sched: randomized and directed bench for rom_dl_sched against a queue-based reference model
module tb_rom_dl_sched;
  localparam logic [24:0] SP = 25'h30000;
  localparam logic [24:0] PB = 25'hA0000;
  localparam int H = 16;
  logic clk_sys = 0, reset = 1, user_reset = 0, ioctl_downl = 0, ioctl_wr = 0;
  logic [24:0] ioctl_addr = 0;
  logic [7:0] ioctl_dout = 0;
  logic port1_ack = 0, port2_ack = 0;
  logic port1_req, port2_req, prom_wr, rom_loaded, core_reset, overflow;
  logic [22:0] port1_a, port2_a;
  logic [1:0] port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic [11:0] prom_addr;
  logic [7:0] prom_d;
  rom_dl_sched #(.SP_BASE(SP), .PROM_BASE(PB), .RESET_HOLD(16'd16)) dut (
    .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset), .ioctl_downl(ioctl_downl),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
    .prom_wr(prom_wr), .prom_addr(prom_addr), .prom_d(prom_d),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .overflow(overflow)
  );
  always #5 clk_sys = ~clk_sys;
  int checks = 0, errors = 0;
  int cyc = 0, dly1 = 4, dly2 = 4, c1 = 0, c2 = 0;
  int n1 = 0, n2 = 0, np = 0, t_load = 0, t_fall = 0;
  logic l1 = 0, l2 = 0, l_ld = 0, l_cr = 0, rs;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  logic [32:0] q[$];
  logic [32:0] it;
  logic [24:0] ma, off;
  logic m_wr_prev = 0, m_dl_prev = 0, m_busy = 0, m_p2 = 0, m_pend = 0, cap, fall, idle_empty, cond;
  logic e_req1 = 0, e_req2 = 0, e_prom_wr = 0, e_loaded = 0, e_ovf = 0, e_core = 1;
  logic [22:0] e_a1 = 0, e_a2 = 0;
  logic [1:0] e_ds1 = 0, e_ds2 = 0;
  logic [15:0] e_d1 = 0, e_d2 = 0;
  logic [11:0] e_pa = 0;
  logic [7:0] e_pd = 0;
  int age = 0;
  always @(posedge clk_sys) begin
    cyc++;
    cap = ioctl_wr && !m_wr_prev && ioctl_downl;
    fall = m_dl_prev && !ioctl_downl;
    m_wr_prev = ioctl_wr;
    m_dl_prev = ioctl_downl;
    if (reset) begin
      q.delete();
      {m_busy, m_p2, m_pend, e_req1, e_req2, e_prom_wr, e_loaded, e_ovf} = '0;
      {e_a1, e_a2, e_ds1, e_ds2, e_d1, e_d2, e_pa, e_pd} = '0;
      e_core = 1;
      age = 0;
    end else begin
      idle_empty = !m_busy && q.size() == 0;
      cond = user_reset || ioctl_downl || !e_loaded;
      e_prom_wr = 0;
      if (m_busy) begin
        if (port1_ack == e_req1 && (!m_p2 || port2_ack == e_req2)) m_busy = 0;
      end else if (q.size() != 0) begin
        it = q.pop_front();
        ma = it[32:8];
        e_req1 = ~e_req1;
        e_a1 = ma[23:1];
        e_ds1 = {ma[0], ~ma[0]};
        e_d1 = {it[7:0], it[7:0]};
        m_p2 = ma >= SP;
        if (m_p2) begin
          off = ma - SP;
          e_req2 = ~e_req2;
          e_a2 = off[23:1];
          e_ds2 = {off[0], ~off[0]};
          e_d2 = {it[7:0], it[7:0]};
        end
        if (ma >= PB && ma < PB + 25'd4096) begin
          off = ma - PB;
          e_prom_wr = 1;
          e_pa = off[11:0];
          e_pd = it[7:0];
        end
        m_busy = 1;
      end
      if (cap) begin
        if (q.size() != 0) e_ovf = 1;
        else q.push_back({ioctl_addr, ioctl_dout});
      end
      m_pend = m_pend || fall;
      if (m_pend && idle_empty) begin
        e_loaded = 1;
        m_pend = 0;
      end
      e_core = age < H;
      age = cond ? 0 : (age < 1000 ? age + 1 : age);
    end
  end
  always @(negedge clk_sys) begin
    if (cyc > 0) begin
      chk("port1_req", port1_req, e_req1);
      chk("port1_a", port1_a, e_a1);
      chk("port1_ds", port1_ds, e_ds1);
      chk("port1_d", port1_d, e_d1);
      chk("port2_req", port2_req, e_req2);
      chk("port2_a", port2_a, e_a2);
      chk("port2_ds", port2_ds, e_ds2);
      chk("port2_d", port2_d, e_d2);
      chk("prom_wr", prom_wr, e_prom_wr);
      chk("prom_addr", prom_addr, e_pa);
      chk("prom_d", prom_d, e_pd);
      chk("rom_loaded", rom_loaded, e_loaded);
      chk("overflow", overflow, e_ovf);
      chk("core_reset", core_reset, e_core);
      if (port1_req !== l1) n1++;
      if (port2_req !== l2) n2++;
      if (prom_wr === 1'b1) np++;
      if (rom_loaded === 1'b1 && l_ld === 1'b0) t_load = cyc;
      if (core_reset === 1'b0 && l_cr === 1'b1) t_fall = cyc;
      l1 = port1_req;
      l2 = port2_req;
      l_ld = rom_loaded;
      l_cr = core_reset;
    end
  end
  always @(posedge clk_sys) begin
    rs = reset;
    #2;
    if (rs) begin
      port1_ack = 0;
      port2_ack = 0;
      c1 = 0;
      c2 = 0;
    end else begin
      if (port1_req !== port1_ack) begin
        if (c1 >= dly1) begin port1_ack = port1_req; c1 = 0; end else c1++;
      end
      if (port2_req !== port2_ack) begin
        if (c2 >= dly2) begin port2_ack = port2_req; c2 = 0; end else c2++;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask
  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input int len = 1, input int gap = 1);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1;
    tick(len);
    ioctl_wr = 0;
    tick(gap);
  endtask
  int b1, b2, bp, tu, r, sel;
  logic [24:0] ra;
  initial begin
    reset = 1;
    ioctl_downl = 1;
    tick(3);
    chk("rst_port1_req", port1_req, 0);
    chk("rst_port1_a", port1_a, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_prom_wr", prom_wr, 0);
    reset = 0;
    tick(2);
    b1 = n1; b2 = n2; bp = np;
    strobe(25'h00005, 8'hA5);
    tick(12);
    chk("s1_req1_toggles", n1 - b1, 1);
    chk("s1_req2_toggles", n2 - b2, 0);
    chk("s1_prom_pulses", np - bp, 0);
    chk("s1_a", port1_a, 23'h2);
    chk("s1_ds", port1_ds, 2'b10);
    chk("s1_d", port1_d, 16'hA5A5);
    dly1 = 3; dly2 = 13;
    b1 = n1; b2 = n2;
    strobe(25'h30001, 8'h3C);
    strobe(25'h00010, 8'h55);
    tick(6);
    chk("s2_held_req1", n1 - b1, 1);
    chk("s2_p1_a", port1_a, 23'h18000);
    chk("s2_p1_ds", port1_ds, 2'b10);
    chk("s2_p2_a", port2_a, 23'h0);
    chk("s2_p2_ds", port2_ds, 2'b10);
    chk("s2_p2_d", port2_d, 16'h3C3C);
    tick(20);
    chk("s2_next_req1", n1 - b1, 2);
    chk("s2_req2_toggles", n2 - b2, 1);
    chk("s2_next_a", port1_a, 23'h8);
    chk("s2_next_ds", port1_ds, 2'b01);
    chk("s2_p2_hold", port2_a, 23'h0);
    dly1 = 2; dly2 = 2;
    b1 = n1; b2 = n2; bp = np;
    strobe(25'hA0302, 8'h7E);
    tick(10);
    chk("s3_prom_pulses", np - bp, 1);
    chk("s3_prom_addr", prom_addr, 12'h302);
    chk("s3_prom_d", prom_d, 8'h7E);
    chk("s3_req1", n1 - b1, 1);
    chk("s3_req2", n2 - b2, 1);
    chk("s3_p1_a", port1_a, 23'h50181);
    chk("s3_p2_a", port2_a, 23'h38181);
    chk("s3_p2_ds", port2_ds, 2'b01);
    chk("s4_no_ovf_yet", overflow, 0);
    dly1 = 20;
    b1 = n1;
    strobe(25'h00100, 8'h11);
    strobe(25'h00103, 8'h22);
    strobe(25'h00104, 8'h33);
    chk("s4_overflow", overflow, 1);
    tick(30);
    chk("s4_req1", n1 - b1, 2);
    chk("s4_a", port1_a, 23'h81);
    chk("s4_ds", port1_ds, 2'b10);
    chk("s4_d", port1_d, 16'h2222);
    dly1 = 10;
    strobe(25'h00200, 8'h99);
    ioctl_downl = 0;
    tick(3);
    chk("s5_not_loaded", rom_loaded, 0);
    tick(20);
    chk("s5_loaded", rom_loaded, 1);
    tick(20);
    chk("s5_core_low", core_reset, 0);
    chk("s5_core_delay", t_fall - t_load, 17);
    user_reset = 1;
    tick(1);
    tu = cyc;
    user_reset = 0;
    tick(25);
    chk("s5_user_delay", t_fall - tu, 17);
    chk("s5_loaded_kept", rom_loaded, 1);
    ioctl_downl = 1;
    dly1 = 20;
    strobe(25'h00300, 8'h01);
    tick(2);
    reset = 1;
    tick(1);
    reset = 0;
    chk("rst_mid_req1", port1_req, 0);
    chk("rst_mid_loaded", rom_loaded, 0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      dly1 = $urandom_range(0, 6);
      dly2 = $urandom_range(0, 6);
      if (r < 2) begin
        reset = 1;
        tick(1);
        reset = 0;
      end else if (r < 8) begin
        ioctl_downl = ~ioctl_downl;
        tick($urandom_range(1, 3));
      end else begin
        sel = $urandom_range(0, 4);
        ra = sel == 0 ? 25'($urandom_range(0, 'h2FFFF)) :
             sel == 1 ? SP + 25'($urandom_range(0, 'h6FFFF)) :
             sel == 2 ? PB + 25'($urandom_range(0, 4095)) :
             sel == 3 ? PB + 25'd4096 - 25'($urandom_range(0, 3)) : SP - 25'($urandom_range(0, 2));
        strobe(ra, 8'($urandom), $urandom_range(1, 3), $urandom_range(1, 4));
      end
    end
    ioctl_downl = 0;
    tick(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
